hsv2rgb_pipe: RTL and testbench
===============================

// Module: hsv2rgb_pipe
// PURPOSE
//  Parametrised, fully pipelined HSV->RGB colour converter with valid/ready flow control on both sides
//  and a pass-through user sideband. Successor of the fixed 8-bit hsv2rgb converter. Sits between the
//  colour generator and the pixel/LED output path; accepts one sample per clock when unstalled.
// PARAMETERS
//  W       8  bits per component (h, s, v, r, g, b); full hue circle = 2^W; M = 2^W-1
//  USER_W  1  width of sideband carried alongside each sample (e.g. sof/eol flags)
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  h, s, v      in   W       hue, saturation, value of the input sample
//  user_i       in   USER_W  sideband, travels with its sample
//  in_valid_i   in   1       input sample valid
//  in_ready_o   out  1       block can accept; transfer when in_valid_i & in_ready_o at rising edge
//  r, g, b      out  W       converted colour
//  user_o       out  USER_W  sideband of the sample on r/g/b
//  out_valid_o  out  1       r/g/b/user_o valid
//  out_ready_i  in   1       sink accepts; transfer when out_valid_o & out_ready_i at rising edge
// BEHAVIOUR
//  - Reset (async): all stage valid bits 0; out_valid_o=0; r,g,b,user_o=0. in_ready_o=1 once reset is low.
//  - mul(a,b): t=a*b+2^(W-1); result=(t+(t>>W))>>W (= round(a*b/M)). Exact; no saturation needed.
//  - Stage 1: hh=6*h (W+3 bits), sector=hh>>W (0..5), f=hh[W-1:0]; register s, v, user.
//  - Stage 2: p=mul(v,M-s); sf=mul(s,f); sg=mul(s,M-f).
//  - Stage 3: q=mul(v,M-sf); t=mul(v,M-sg).
//  - Stage 4 (output reg): sector 0:(v,t,p) 1:(q,v,p) 2:(p,v,t) 3:(p,q,v) 4:(t,p,v) 5:(v,p,q).
//  - Latency: sample accepted at edge E0 appears on r/g/b with out_valid_o=1 after edge E0+3;
//    sustained throughput of 1 sample/clock while out_ready_i=1.
//  - Flow control, per-stage bubble collapse: en[k] = !vld[k] | en[k+1]; en[4] = !out_valid_o | out_ready_i;
//    in_ready_o = en[1]. A stage loads only when en[k]. Max 4 samples in flight.
//  - While out_valid_o=1 and out_ready_i=0, r/g/b/user_o stay stable; no sample is dropped or duplicated.
//  - Simultaneous out transfer and full pipe: in_ready_o=1 in the same cycle (combinational ready chain).
//  - Order preserved; user_o always matches its sample.
//  - in_valid_i=0 inserts a bubble; bubbles are squeezed out under backpressure.
//  - s=0 -> r=g=b=v for any h. v=0 -> r=g=b=0.
//  - Reset asserted mid-stream: all in-flight samples are discarded; outputs go to 0 immediately.
//  - Data inputs are don't-care (may be X) when in_valid_i=0; X must not propagate to out_valid_o.
// TESTING
//  1. W=8, h=50,s=100,v=150, out_ready_i=1 -> after 4 edges r,g,b=140,150,91, single out_valid_o pulse.
//  2. Back-to-back (50,100,150),(200,150,50),(0,255,255),(x,0,200) -> (140,150,91),(41,21,50),
//     (255,0,0),(200,200,200) on 4 consecutive cycles, user_o tags in order.
//  3. out_ready_i=0, offer 5 samples -> 4 accepted, in_ready_o=0 on 5th; outputs held stable;
//     release -> all 5 emerge in order, none lost or repeated.
//  4. Random in_valid_i/out_ready_i for 10k samples vs. reference model using mul() -> exact match,
//     sample count in == out.
//  5. Sweep h 0..255 with s=255,v=255 -> sector boundaries at h=43,86,128,171,214 correct, no wrap error at h=255.
//  6. Assert reset with 3 samples in flight -> out_valid_o=0, r/g/b=0 asynchronously; after release
//     no stale output appears.

Source files
------------

// File: rtl/hsv2rgb_pipe.sv
// hsv2rgb_pipe: pipelined HSV to RGB converter with valid/ready flow control and user sideband
module hsv2rgb_pipe #(
  parameter int W = 8,
  parameter int USER_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [W-1:0]      h,
  input  logic [W-1:0]      s,
  input  logic [W-1:0]      v,
  input  logic [USER_W-1:0] user_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [W-1:0]      r,
  output logic [W-1:0]      g,
  output logic [W-1:0]      b,
  output logic [USER_W-1:0] user_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);
  localparam logic [W-1:0] M = '1;
  function automatic logic [W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W:0] t;
    t = (2*W+1)'(x) * (2*W+1)'(y) + (2*W+1)'(1 << (W-1));
    return W'((t + (t >> W)) >> W);
  endfunction
  logic              vld1, vld2, vld3;
  logic              en1, en2, en3, en4;
  logic [W+2:0]      hh;
  logic [2:0]        sec1, sec2, sec3;
  logic [W-1:0]      f1, s1, v1, v2, p2, sf2, sg2, v3, p3, q3, t3;
  logic [USER_W-1:0] u1, u2, u3;
  logic [W-1:0]      rn, gn, bn;
  // a stage may load whenever it is empty or the stage after it is moving
  assign en4 = !out_valid_o | out_ready_i;
  assign en3 = !vld3 | en4;
  assign en2 = !vld2 | en3;
  assign en1 = !vld1 | en2;
  assign in_ready_o = en1;
  assign hh = (W+3)'(h) * (W+3)'(6);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      vld1 <= 1'b0;
      {sec1, f1, s1, v1, u1} <= '0;
    end else if (en1) begin
      vld1 <= in_valid_i;
      if (in_valid_i) {sec1, f1, s1, v1, u1} <= {hh[W+2:W], hh[W-1:0], s, v, user_i};
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      vld2 <= 1'b0;
      {sec2, u2, v2, p2, sf2, sg2} <= '0;
    end else if (en2) begin
      vld2 <= vld1;
      if (vld1) {sec2, u2, v2, p2, sf2, sg2} <= {sec1, u1, v1, mul(v1, M - s1), mul(s1, f1), mul(s1, M - f1)};
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      vld3 <= 1'b0;
      {sec3, u3, v3, p3, q3, t3} <= '0;
    end else if (en3) begin
      vld3 <= vld2;
      if (vld2) {sec3, u3, v3, p3, q3, t3} <= {sec2, u2, v2, p2, mul(v2, M - sf2), mul(v2, M - sg2)};
    end
  always_comb begin
    rn = (sec3 == 3'd0 || sec3 == 3'd5) ? v3 : (sec3 == 3'd1) ? q3 : (sec3 == 3'd4) ? t3 : p3;
    gn = (sec3 == 3'd1 || sec3 == 3'd2) ? v3 : (sec3 == 3'd0) ? t3 : (sec3 == 3'd3) ? q3 : p3;
    bn = (sec3 == 3'd3 || sec3 == 3'd4) ? v3 : (sec3 == 3'd2) ? t3 : (sec3 == 3'd5) ? q3 : p3;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_valid_o <= 1'b0;
      {r, g, b, user_o} <= '0;
    end else if (en4) begin
      out_valid_o <= vld3;
      if (vld3) {r, g, b, user_o} <= {rn, gn, bn, u3};
    end
endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// tb_hsv2rgb_pipe: directed and randomized checks of the HSV to RGB pipeline
module tb_hsv2rgb_pipe;
  localparam int W = 8;
  localparam int UW = 4;
  typedef struct packed {logic [7:0] h; logic [23:0] rgb; logic [UW-1:0] u;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0] h = '0, s = '0, v = '0;
  logic [UW-1:0] user_i = '0;
  logic in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic in_ready_o, out_valid_o;
  logic [W-1:0] r, g, b;
  logic [UW-1:0] user_o;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int vh[5] = '{50, 200, 0, 123, 42};
  int vs[5] = '{100, 150, 255, 0, 255};
  int vv[5] = '{150, 50, 255, 200, 255};
  int er[5] = '{140, 41, 255, 200, 255};
  int eg[5] = '{150, 21, 0, 200, 252};
  int eb[5] = '{91, 50, 0, 200, 0};
  int bh[9] = '{0, 42, 43, 85, 86, 128, 171, 214, 255};
  int br[9] = '{255, 255, 253, 1, 0, 0, 2, 255, 255};
  int bg[9] = '{0, 252, 255, 255, 255, 255, 0, 0, 0};
  int bb[9] = '{0, 0, 0, 0, 4, 255, 255, 251, 5};
  hsv2rgb_pipe #(.W(W), .USER_W(UW)) dut (
    .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .user_i(user_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .r(r), .g(g), .b(b),
    .user_o(user_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );
  always #5 clock = ~clock;
  function automatic int m(int a, int c);
    return (2 * a * c + 255) / 510;
  endfunction
  function automatic logic [23:0] model(int hv, int sv, int vl);
    int x, sec, f, p, qq, t;
    x = 6 * hv;
    sec = x / 256;
    f = x % 256;
    p = m(vl, 255 - sv);
    qq = m(vl, 255 - m(sv, f));
    t = m(vl, 255 - m(sv, 255 - f));
    case (sec)
      0: return {8'(vl), 8'(t), 8'(p)};
      1: return {8'(qq), 8'(vl), 8'(p)};
      2: return {8'(p), 8'(vl), 8'(t)};
      3: return {8'(p), 8'(qq), 8'(vl)};
      4: return {8'(t), 8'(p), 8'(vl)};
      default: return {8'(vl), 8'(p), 8'(qq)};
    endcase
  endfunction
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || {r, g, b, user_o} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b rgb=%h user=%h want 0", out_valid_o, {r, g, b}, user_o);
    end
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b want 1", in_ready_o);
    end
  endtask
  task automatic test_single;
    tick;
    h = 8'd50; s = 8'd100; v = 8'd150; user_i = 4'h5; in_valid_i = 1'b1; out_ready_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid_o !== 1'(i == 3)) begin
        failures++;
        $display("FAIL single_valid edge+%0d got %b want %b", i, out_valid_o, i == 3);
      end
      if (i == 3) begin
        checks++;
        if ({r, g, b} !== {8'd140, 8'd150, 8'd91} || user_o !== 4'h5) begin
          failures++;
          $display("FAIL single_rgb got %0d,%0d,%0d u=%h want 140,150,91 u=5", r, g, b, user_o);
        end
      end
      tick;
    end
  endtask
  task automatic test_back_to_back;
    tick;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      h = 8'(vh[i]); s = 8'(vs[i]); v = 8'(vv[i]); user_i = 4'(i + 1); in_valid_i = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready sample %0d got %b want 1", i, in_ready_o);
      end
      tick;
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid_o !== 1'b1 || {r, g, b} !== {8'(er[i]), 8'(eg[i]), 8'(eb[i])} || user_o !== 4'(i + 1)) begin
        failures++;
        $display("FAIL b2b_out %0d got v=%b %0d,%0d,%0d u=%0d want 1 %0d,%0d,%0d u=%0d",
                 i, out_valid_o, r, g, b, user_o, er[i], eg[i], eb[i], i + 1);
      end
      tick;
    end
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tail got valid=%b want 0", out_valid_o);
    end
  endtask
  task automatic test_backpressure;
    int got;
    bit clr;
    tick;
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      h = 8'(vh[i]); s = 8'(vs[i]); v = 8'(vv[i]); user_i = 4'(i + 8); in_valid_i = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'(i < 4)) begin
        failures++;
        $display("FAIL bp_ready sample %0d got %b want %b", i, in_ready_o, i < 4);
      end
      if (i < 4) tick;
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      #1;
      checks++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || {r, g, b} !== {8'd140, 8'd150, 8'd91} || user_o !== 4'd8) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got rdy=%b v=%b %0d,%0d,%0d u=%0d want 0 1 140,150,91 u=8",
                 k, in_ready_o, out_valid_o, r, g, b, user_o);
      end
    end
    out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got %b want 1", in_ready_o);
    end
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid_o) begin
        checks++;
        if (got >= 5) begin
          failures++;
          $display("FAIL bp_extra got output %0d want only 5", got);
        end else if ({r, g, b} !== {8'(er[got]), 8'(eg[got]), 8'(eb[got])} || user_o !== 4'(got + 8)) begin
          failures++;
          $display("FAIL bp_out %0d got %0d,%0d,%0d u=%0d want %0d,%0d,%0d u=%0d",
                   got, r, g, b, user_o, er[got], eg[got], eb[got], got + 8);
        end
        got++;
      end
      clr = in_valid_i && in_ready_o;
      tick;
      if (clr) in_valid_i = 1'b0;
      #1;
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL bp_count got %0d want 5", got);
    end
  endtask
  task automatic test_sweep;
    exp_t e;
    int sent;
    tick;
    out_ready_i = 1'b1;
    sent = 0;
    for (int c = 0; c < 270; c++) begin
      in_valid_i = sent < 256;
      h = 8'(sent); s = 8'd255; v = 8'd255; user_i = 4'(sent);
      #1;
      if (out_valid_o) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sweep_spurious got output %0d,%0d,%0d want none", r, g, b);
        end else begin
          e = q.pop_front();
          if ({r, g, b} !== e.rgb || user_o !== e.u) begin
            failures++;
            $display("FAIL sweep h=%0d got %h u=%h want %h u=%h", e.h, {r, g, b}, user_o, e.rgb, e.u);
          end
          for (int j = 0; j < 9; j++)
            if (e.h == 8'(bh[j])) begin
              checks++;
              if ({r, g, b} !== {8'(br[j]), 8'(bg[j]), 8'(bb[j])}) begin
                failures++;
                $display("FAIL sweep_boundary h=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                         bh[j], r, g, b, br[j], bg[j], bb[j]);
              end
            end
        end
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back('{h: h, rgb: model(sent, 255, 255), u: user_i});
        sent++;
      end
      tick;
    end
    in_valid_i = 1'b0;
    checks++;
    if (sent != 256 || q.size() != 0) begin
      failures++;
      $display("FAIL sweep_count got sent=%0d left=%0d want 256 0", sent, q.size());
    end
  endtask
  task automatic test_random;
    exp_t e;
    int sent, recv;
    tick;
    sent = 0;
    recv = 0;
    q.delete();
    for (int c = 0; c < 60000 && (sent < 10000 || q.size() > 0); c++) begin
      in_valid_i = sent < 10000 && $urandom_range(3) != 0;
      h = 8'($urandom); s = 8'($urandom); v = 8'($urandom); user_i = 4'($urandom);
      out_ready_i = $urandom_range(3) != 0;
      #1;
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious got %h want no output", {r, g, b});
        end else begin
          e = q.pop_front();
          if ({r, g, b} !== e.rgb || user_o !== e.u) begin
            failures++;
            $display("FAIL rand_out %0d got %h u=%h want %h u=%h", recv, {r, g, b}, user_o, e.rgb, e.u);
          end
        end
        recv++;
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back('{h: h, rgb: model(int'(h), int'(s), int'(v)), u: user_i});
        sent++;
      end
      tick;
    end
    in_valid_i = 1'b0;
    checks++;
    if (sent != 10000 || recv != sent || q.size() != 0) begin
      failures++;
      $display("FAIL rand_count got in=%0d out=%0d left=%0d want 10000 10000 0", sent, recv, q.size());
    end
  endtask
  task automatic test_reset_midstream;
    bit stale;
    tick;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      h = 8'(vh[i]); s = 8'(vs[i]); v = 8'(vv[i]); user_i = 4'(i + 1); in_valid_i = 1'b1;
      tick;
    end
    in_valid_i = 1'b0;
    tick;
    tick;
    #1;
    checks++;
    if (out_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got valid=%b want 1", out_valid_o);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || {r, g, b, user_o} !== '0) begin
      failures++;
      $display("FAIL mid_async got valid=%b rgb=%h u=%h want 0", out_valid_o, {r, g, b}, user_o);
    end
    tick;
    reset = 1'b0;
    out_ready_i = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid_o) stale = 1'b1;
      tick;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL mid_stale got stale output want none");
    end
    h = 8'(vh[1]); s = 8'(vs[1]); v = 8'(vv[1]); user_i = 4'd7; in_valid_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    tick;
    tick;
    tick;
    #1;
    checks++;
    if (out_valid_o !== 1'b1 || {r, g, b} !== {8'd41, 8'd21, 8'd50} || user_o !== 4'd7) begin
      failures++;
      $display("FAIL mid_after got v=%b %0d,%0d,%0d u=%0d want 1 41,21,50 u=7", out_valid_o, r, g, b, user_o);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_sweep;
    test_random;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
